// File: rtl/cic_seq_pkg.sv
// Shared types and constants for the CIC decimator control slice.
package cic_seq_pkg;

    localparam int DEC_W        = 15;  // decimation count width (R = count + 1)
    localparam int SHIFT_W      = 6;   // CIC gainShift width
    localparam int HEADROOM_DEF = 30;  // 48-bit accumulator minus 18-bit input

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cic_gain_calc.sv
// Maps a decimation count to the CIC gain shift: shift = HEADROOM - 3*clog2(R),
// saturating at 0 (and flagging it) when the growth exceeds the headroom.
module cic_gain_calc
    import cic_seq_pkg::*;
#(
    parameter int HEADROOM = HEADROOM_DEF
) (
    input  logic [DEC_W-1:0]   decimation,
    output logic [SHIFT_W-1:0] shift,
    output logic               clamped
);

    logic [4:0]         log2r;
    logic [SHIFT_W-1:0] growth;

    // clog2(count+1) equals the index of the count's top set bit plus one (0 for count 0)
    always_comb begin
        log2r = '0;
        for (int i = 0; i < DEC_W; i++) begin
            if (decimation[i]) log2r = 5'(i + 1);
        end
    end

    assign growth = SHIFT_W'(log2r) * SHIFT_W'(3);

    // subtract the bit growth from the headroom, saturating at zero
    always_comb begin
        if (growth <= SHIFT_W'(HEADROOM)) begin
            shift   = SHIFT_W'(HEADROOM) - growth;
            clamped = 1'b0;
        end else begin
            shift   = '0;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/cic_decim_sequencer.sv
// CIC decimator control: latches decimation/gain config, flushes the CIC after
// every change, drops the settling outputs and flags clean samples.
module cic_decim_sequencer
    import cic_seq_pkg::*;
#(
    parameter int FLUSH_CYCLES       = 4,
    parameter int SETTLE_OUTPUTS     = 4,
    parameter int HEADROOM           = HEADROOM_DEF,
    parameter int DEFAULT_DECIMATION = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [DEC_W-1:0]   cfg_decimation,
    input  logic               cfg_gain_override,
    input  logic [SHIFT_W-1:0] cfg_gain_shift,
    input  logic               cic_sync_out,
    output logic               cic_reset,
    output logic [DEC_W-1:0]   cic_decimation,
    output logic [SHIFT_W-1:0] cic_gain_shift,
    output logic               sample_valid,
    output logic               busy,
    output logic               growth_clamped
);

    // one counter serves both the flush cycle count and the settle strobe count
    localparam int CNT_MAX = (FLUSH_CYCLES > SETTLE_OUTPUTS) ? FLUSH_CYCLES : SETTLE_OUTPUTS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DEC_W-1:0]   calc_dec;
    logic [SHIFT_W-1:0] auto_shift;
    logic               auto_clamped;

    // the single gain calculator sees the default ratio during reset, the written one otherwise
    assign calc_dec = reset ? DEC_W'(DEFAULT_DECIMATION) : cfg_decimation;

    cic_gain_calc #(.HEADROOM(HEADROOM)) u_gain (
        .decimation (calc_dec),
        .shift      (auto_shift),
        .clamped    (auto_clamped)
    );

    // config registers: reset default, or take the write (manual shift when overridden)
    always_ff @(posedge clk) begin
        if (reset) begin
            cic_decimation <= DEC_W'(DEFAULT_DECIMATION);
            cic_gain_shift <= auto_shift;
            growth_clamped <= 1'b0;
        end else if (cfg_wr) begin
            cic_decimation <= cfg_decimation;
            cic_gain_shift <= cfg_gain_override ? cfg_gain_shift : auto_shift;
            growth_clamped <= cfg_gain_override ? 1'b0 : auto_clamped;
        end
    end

    // sequencer state and counter; reset starts a full flush
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state: any write restarts the flush; flush counts cycles, settle counts strobes
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (cfg_wr) begin
            state_n = ST_FLUSH;
            cnt_n   = CNT_W'(FLUSH_CYCLES);
        end else begin
            case (state)
                ST_RUN: ;
                ST_FLUSH: begin
                    if (cnt == CNT_W'(1)) begin
                        state_n = ST_SETTLE;
                        cnt_n   = CNT_W'(SETTLE_OUTPUTS);
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cic_sync_out) begin
                        if (cnt == CNT_W'(1)) state_n = ST_RUN;
                        else                  cnt_n   = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_FLUSH;
                    cnt_n   = CNT_W'(FLUSH_CYCLES);
                end
            endcase
        end
    end

    // a strobe is only passed on in steady RUN and not when a reconfig lands with it
    always_ff @(posedge clk) begin
        if (reset) sample_valid <= 1'b0;
        else       sample_valid <= (state == ST_RUN) && cic_sync_out && !cfg_wr;
    end

    assign cic_reset = (state == ST_FLUSH);
    assign busy      = (state != ST_RUN);

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Randomised and directed bench for cic_decim_sequencer against a timestamp model.
module tb_cic_decim_sequencer;

    localparam int F   = 4;
    localparam int S   = 4;
    localparam int HR  = 30;
    localparam int DEF = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [14:0] cfg_decimation = '0;
    logic        cfg_gain_override = 1'b0;
    logic [5:0]  cfg_gain_shift = '0;
    logic        cic_sync_out = 1'b0;
    logic        cic_reset;
    logic [14:0] cic_decimation;
    logic [5:0]  cic_gain_shift;
    logic        sample_valid;
    logic        busy;
    logic        growth_clamped;

    cic_decim_sequencer #(
        .FLUSH_CYCLES(F), .SETTLE_OUTPUTS(S), .HEADROOM(HR), .DEFAULT_DECIMATION(DEF)
    ) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_decimation(cfg_decimation),
        .cfg_gain_override(cfg_gain_override), .cfg_gain_shift(cfg_gain_shift),
        .cic_sync_out(cic_sync_out), .cic_reset(cic_reset), .cic_decimation(cic_decimation),
        .cic_gain_shift(cic_gain_shift), .sample_valid(sample_valid), .busy(busy),
        .growth_clamped(growth_clamped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: config values, edge count, edge at which the last flush began, strobes counted since
    int cyc = 0;
    int m_start = 0;
    int m_strobes = 0;
    int m_dec = DEF;
    int m_shift = 27;
    bit m_clamp = 1'b0;
    bit m_valid = 1'b0;

    logic [24:0] dut_vec;
    assign dut_vec = {cic_reset, busy, sample_valid, growth_clamped, cic_gain_shift, cic_decimation};

    function automatic void gain_model(input int dec, output int shift, output bit clamp);
        int r;
        int n;
        r = dec + 1;
        n = 0;
        while ((1 << n) < r) n++;
        if (3 * n <= HR) begin shift = HR - 3 * n; clamp = 1'b0; end
        else             begin shift = 0;          clamp = 1'b1; end
    endfunction

    function automatic logic [24:0] exp_vec();
        bit fl;
        bit bz;
        fl = (cyc - m_start) < F;
        bz = fl || (m_strobes < S);
        return {fl, bz, m_valid, m_clamp, 6'(m_shift), 15'(m_dec)};
    endfunction

    // one clock edge; the model consumes the inputs that the DUT sampled at the same edge
    task automatic tick();
        bit fl, st, run, cl;
        int sh;
        @(posedge clk);
        fl  = (cyc - m_start) < F;
        st  = !fl && (m_strobes < S);
        run = !fl && !st;
        cyc++;
        if (reset) begin
            m_dec = DEF;
            gain_model(DEF, sh, cl);
            m_shift = sh; m_clamp = 1'b0;
            m_start = cyc; m_strobes = 0; m_valid = 1'b0;
        end else begin
            m_valid = run && cic_sync_out && !cfg_wr;
            if (cfg_wr) begin
                m_dec = int'(cfg_decimation);
                if (cfg_gain_override) begin
                    m_shift = int'(cfg_gain_shift); m_clamp = 1'b0;
                end else begin
                    gain_model(int'(cfg_decimation), sh, cl);
                    m_shift = sh; m_clamp = cl;
                end
                m_start = cyc; m_strobes = 0;
            end else if (st && cic_sync_out) begin
                m_strobes++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int hi, nv, at;
        reset = 1'b1; cfg_wr = 1'b1; cfg_decimation = 15'd500;
        tick(); tick();
        cfg_wr = 1'b0;
        checks++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd27, 15'd1}) begin
            failures++; $display("FAIL reset_values: got %h want %h", dut_vec, {1'b1, 1'b1, 1'b0, 1'b0, 6'd27, 15'd1});
        end
        reset = 1'b0;
        hi = cic_reset ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL reset_flush c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (cic_reset) hi++;
        end
        checks++;
        if (hi !== 4) begin failures++; $display("FAIL reset_flush_len: got %0d want 4", hi); end
        nv = 0; at = -1;
        for (int p = 0; p < 5; p++) begin
            cic_sync_out = 1'b1; tick(); cic_sync_out = 1'b0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL reset_settle p%0d: got %h want %h", p, dut_vec, exp_vec());
            end
            if (sample_valid) begin nv++; at = p; end
            tick();
        end
        checks++;
        if (nv !== 1 || at !== 4) begin
            failures++; $display("FAIL reset_first_valid: got count %0d at %0d want 1 at 4", nv, at);
        end
    endtask

    task automatic test_auto_gain();
        int decs[5]   = '{7, 99, 1023, 1024, 0};
        int shifts[5] = '{21, 9, 0, 0, 30};
        bit clamps[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cfg_gain_override = 1'b0; cfg_decimation = 15'(decs[i]); cfg_wr = 1'b1;
            tick();
            cfg_wr = 1'b0;
            checks++;
            if ({growth_clamped, cic_gain_shift, cic_decimation} !== {clamps[i], 6'(shifts[i]), 15'(decs[i])}) begin
                failures++;
                $display("FAIL auto_gain dec=%0d: got clamp %b shift %0d want clamp %b shift %0d",
                         decs[i], growth_clamped, cic_gain_shift, clamps[i], shifts[i]);
            end
            for (int c = 0; c < 20; c++) begin
                cic_sync_out = (c >= 4) && c[0];
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++; $display("FAIL auto_seq dec=%0d c%0d: got %h want %h", decs[i], c, dut_vec, exp_vec());
                end
            end
            cic_sync_out = 1'b0;
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL auto_done dec=%0d: busy %b want 0", decs[i], busy); end
        end
    endtask

    task automatic test_override();
        cfg_gain_override = 1'b1; cfg_gain_shift = 6'd12; cfg_decimation = 15'd99; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0; cfg_gain_override = 1'b0; cfg_gain_shift = 6'd0;
        checks++;
        if ({growth_clamped, cic_gain_shift, cic_decimation} !== {1'b0, 6'd12, 15'd99}) begin
            failures++; $display("FAIL override_cfg: got clamp %b shift %0d dec %0d want 0 12 99",
                                 growth_clamped, cic_gain_shift, cic_decimation);
        end
        for (int c = 0; c < 16; c++) begin
            cic_sync_out = c[0];
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL override_seq c%0d: got %h want %h", c, dut_vec, exp_vec());
            end
            checks++;
            if (c < 10 && busy !== 1'b1) begin failures++; $display("FAIL override_busy c%0d: busy %b want 1", c, busy); end
        end
        cic_sync_out = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL override_done: busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int hi, nv;
        cfg_decimation = 15'd3; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        for (int p = 0; p < 2; p++) begin
            cic_sync_out = 1'b1; tick(); cic_sync_out = 1'b0; tick();
        end
        checks++;
        if (dut_vec !== exp_vec()) begin failures++; $display("FAIL b2b_mid_settle: got %h want %h", dut_vec, exp_vec()); end
        cfg_decimation = 15'd15; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        hi = cic_reset ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cic_reset) hi++;
        end
        checks++;
        if (hi !== 4) begin failures++; $display("FAIL b2b_flush_len: got %0d want 4", hi); end
        nv = 0;
        for (int p = 0; p < 4; p++) begin
            cic_sync_out = 1'b1; tick(); cic_sync_out = 1'b0;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL b2b_settle p%0d: got %h want %h", p, dut_vec, exp_vec()); end
            if (sample_valid) nv++;
            tick();
        end
        checks++;
        if (nv !== 0 || busy !== 1'b0 || cic_decimation !== 15'd15) begin
            failures++; $display("FAIL b2b_final: valids %0d busy %b dec %0d want 0 0 15", nv, busy, cic_decimation);
        end
        // write coinciding with a strobe in RUN suppresses that sample
        cfg_wr = 1'b1; cic_sync_out = 1'b1; tick(); cfg_wr = 1'b0; cic_sync_out = 1'b0;
        checks++;
        if (sample_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL b2b_wr_sync: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_flush_sync();
        cfg_decimation = 15'd63; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        cic_sync_out = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (sample_valid !== 1'b0 || dut_vec !== exp_vec()) begin
                failures++; $display("FAIL flush_sync c%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        cic_sync_out = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cic_sync_out = 1'b1; tick(); cic_sync_out = 1'b0; tick();
        end
        checks++;
        if (busy !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL flush_no_decrement: busy %b vec %h want busy 1 vec %h", busy, dut_vec, exp_vec());
        end
        cic_sync_out = 1'b1; tick(); cic_sync_out = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            failures++; $display("FAIL flush_last_strobe: busy %b valid %b want 0 0", busy, sample_valid);
        end
    endtask

    task automatic test_reset_mid_settle();
        cfg_decimation = 15'd200; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        for (int p = 0; p < 2; p++) begin
            cic_sync_out = 1'b1; tick(); cic_sync_out = 1'b0; tick();
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd27, 15'd1}) begin
            failures++; $display("FAIL midreset_values: got %h want %h", dut_vec, {1'b1, 1'b1, 1'b0, 1'b0, 6'd27, 15'd1});
        end
        for (int c = 0; c < 16; c++) begin
            cic_sync_out = c[0];
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL midreset_seq c%0d: got %h want %h", c, dut_vec, exp_vec()); end
        end
        cic_sync_out = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset             = ($urandom_range(0, 99) == 0);
            cfg_wr            = ($urandom_range(0, 15) == 0);
            cic_sync_out      = ($urandom_range(0, 2) == 0);
            cfg_gain_override = ($urandom_range(0, 3) == 0);
            cfg_gain_shift    = 6'($urandom_range(0, 63));
            cfg_decimation    = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 32767))
                                                            : 15'($urandom_range(0, 2047));
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random c%0d: got %h want %h", c, dut_vec, exp_vec()); end
        end
        reset = 1'b0; cfg_wr = 1'b0; cic_sync_out = 1'b0; cfg_gain_override = 1'b0;
    endtask

    initial begin
        test_reset();
        test_auto_gain();
        test_override();
        test_back_to_back();
        test_flush_sync();
        test_reset_mid_settle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
